// File: rtl/debounce_filter_pkg.sv
// rtl/debounce_filter_pkg.sv - shared state encoding and sizing helper for debounce_filter
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE,
    CHECK_HIGH,
    HIGH_STABLE,
    CHECK_LOW
  } state_t;

  // Stability counter must hold STABLE_CYCLES-1 without overflow.
  function automatic int stab_w(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/debounce_filter_if.sv
// rtl/debounce_filter_if.sv - level input, clear request and debounced outputs of debounce_filter
interface debounce_filter_if #(
  parameter int COUNT_W = 8
) ();

  logic               sync_in;
  logic               clear_cnt;
  logic               level_out;
  logic               rise_pulse;
  logic               fall_pulse;
  logic [COUNT_W-1:0] edge_count;
  logic               count_sat;

  modport master (
    output sync_in,
    output clear_cnt,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  edge_count,
    input  count_sat
  );

  modport slave (
    input  sync_in,
    input  clear_cnt,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output edge_count,
    output count_sat
  );

endinterface

// File: rtl/debounce_filter_sat_counter.sv
// rtl/debounce_filter_sat_counter.sv - saturating event counter with clear that keeps a coincident increment
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = inc ? WIDTH'(1) : '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = &count_q;

endmodule

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - glitch filter with edge pulses and saturating rising-event count
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  debounce_filter_if.slave   bus
);

  localparam int STAB_W = stab_w(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  logic [COUNT_W-1:0] edge_count;
  logic               count_sat;

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    case (state_q)
      LOW_STABLE: begin
        if (bus.sync_in) begin
          state_d    = CHECK_HIGH;
          stab_cnt_d = STAB_W'(1);
        end
      end
      CHECK_HIGH: begin
        if (!bus.sync_in) begin
          state_d    = LOW_STABLE;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = HIGH_STABLE;
          stab_cnt_d = '0;
          level_d    = 1'b1;
          rise_d     = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      HIGH_STABLE: begin
        if (!bus.sync_in) begin
          state_d    = CHECK_LOW;
          stab_cnt_d = STAB_W'(1);
        end
      end
      CHECK_LOW: begin
        if (bus.sync_in) begin
          state_d    = HIGH_STABLE;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = LOW_STABLE;
          stab_cnt_d = '0;
          level_d    = 1'b0;
          fall_d     = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      default: begin
        state_d    = LOW_STABLE;
        stab_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOW_STABLE;
      stab_cnt_q <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  // Counting on rise_d makes edge_count move on the same edge that raises rise_pulse.
  sat_counter #(
    .WIDTH (COUNT_W)
  ) u_edge_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.clear_cnt),
    .inc   (rise_d),
    .count (edge_count),
    .sat   (count_sat)
  );

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.edge_count = edge_count;
  assign bus.count_sat  = count_sat;

endmodule
